// File: rtl/lenet_pkg.sv
// Shared types and defaults for the LeNet pipeline stages.
// Pixel format, feature-map geometry and the pooling streamer's FSM encoding.
package lenet_pkg;

  localparam int PIXEL_W      = 16;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_FMAP_DIM = 28;

  typedef logic signed [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } pool_state_e;

endpackage

// File: rtl/max4_relu.sv
// Combinational 2x2 pooling window: ReLU of the signed max of four pixels.
// The result is either zero or one of the inputs, so no widening is needed.
module max4_relu #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  output logic signed [W-1:0] y
);

  function automatic logic signed [W-1:0] max2(input logic signed [W-1:0] x,
                                               input logic signed [W-1:0] z);
    return (x > z) ? x : z;
  endfunction

  function automatic logic signed [W-1:0] relu(input logic signed [W-1:0] x);
    return x[W-1] ? '0 : x;
  endfunction

  logic signed [W-1:0] m_ab, m_cd;

  assign m_ab = max2(a, b);
  assign m_cd = max2(c, d);
  assign y    = relu(max2(m_ab, m_cd));

endmodule

// File: rtl/fmap_pool_streamer.sv
// Walks a parallel feature map, applies 2x2 max-pool + ReLU and streams
// one pooled pixel per beat on a valid/ready interface.
module fmap_pool_streamer
  import lenet_pkg::*;
#(
  parameter  int BITWIDTH = PIXEL_W,
  parameter  int CHANNELS = DEF_CHANNELS,
  parameter  int FMAP_DIM = DEF_FMAP_DIM,
  localparam int PDIM     = FMAP_DIM / 2,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int PW       = (PDIM > 1) ? $clog2(PDIM) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [CHANNELS-1:0][FMAP_DIM-1:0][FMAP_DIM-1:0][BITWIDTH-1:0] featuremap,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [BITWIDTH-1:0] out_data,
  output logic [CW-1:0]              out_ch,
  output logic [PW-1:0]              out_row,
  output logic [PW-1:0]              out_col,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       done
);

  pool_state_e state, state_nx;

  logic [CW-1:0] ch;
  logic [PW-1:0] r, c;
  logic          accept, load, pop, at_end;

  logic [PW:0]                row0, row1, col0, col1;
  logic signed [BITWIDTH-1:0] w00, w01, w10, w11, pooled_p0;

  // Stage 0: window select and pool/ReLU, straight from the counters
  assign row0 = {r, 1'b0};
  assign row1 = {r, 1'b1};
  assign col0 = {c, 1'b0};
  assign col1 = {c, 1'b1};

  assign w00 = featuremap[ch][row0][col0];
  assign w01 = featuremap[ch][row0][col1];
  assign w10 = featuremap[ch][row1][col0];
  assign w11 = featuremap[ch][row1][col1];

  max4_relu #(.W(BITWIDTH)) u_pool (
    .a (w00),
    .b (w01),
    .c (w10),
    .d (w11),
    .y (pooled_p0)
  );

  assign at_end   = (ch == CW'(CHANNELS - 1)) && (r == PW'(PDIM - 1)) &&
                    (c == PW'(PDIM - 1));
  assign in_ready = (state == IDLE);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    load     = 1'b0;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = STREAM;
        end
      end
      STREAM: begin
        if (!out_valid || out_ready) begin
          load = 1'b1;
          if (at_end) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          pop      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      ch    <= '0;
      r     <= '0;
      c     <= '0;
    end else begin
      state <= state_nx;
      done  <= pop;
      if (accept) begin
        ch <= '0;
        r  <= '0;
        c  <= '0;
      end else if (load) begin
        // c fastest, then r, then ch
        if (c == PW'(PDIM - 1)) begin
          c <= '0;
          if (r == PW'(PDIM - 1)) begin
            r  <= '0;
            ch <= ch + 1'b1;
          end else begin
            r <= r + 1'b1;
          end
        end else begin
          c <= c + 1'b1;
        end
      end
    end
  end

  // Stage 1: output register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= pooled_p0;
      out_ch    <= ch;
      out_row   <= r;
      out_col   <= c;
      out_last  <= at_end;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fmap_pool_streamer.sv
// Bench for fmap_pool_streamer: a per-beat reference model drives a compare
// process, directed frames pin timing and hand-computed pixel values.
module tb_fmap_pool_streamer;

  localparam int BW = 16;
  localparam int CH = 2;
  localparam int FD = 28;
  localparam int PD = FD / 2;
  localparam int NB = CH * PD * PD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [CH-1:0][FD-1:0][FD-1:0][BW-1:0] fm;
  logic in_ready, out_last, out_valid, done;
  logic signed [BW-1:0] out_data;
  logic [0:0] out_ch;
  logic [3:0] out_row, out_col;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int idx = 0;
  int frames = 0;
  int first_cyc = -1;
  int last_hs_cyc = -1;
  int done_cyc = -1;
  bit hold = 1'b0;
  int held = 0;
  bit bp_mode = 1'b0;
  int cap[NB];

  fmap_pool_streamer #(.BITWIDTH(BW), .CHANNELS(CH), .FMAP_DIM(FD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .featuremap (fm),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: ReLU of the max over the 2x2 input window of pooled pixel (ch,r,c)
  function automatic int model_px(input int ch, input int r, input int c);
    int m, v;
    m = -1000000;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        v = int'($signed(fm[ch][2*r+dy][2*c+dx]));
        if (v > m) m = v;
      end
    return (m < 0) ? 0 : m;
  endfunction

  always @(negedge clk) begin
    bit was_hold;
    int ech, er, ec;
    if (!rst_n) begin
      idx  = 0;
      hold = 1'b0;
    end else begin
      was_hold = hold;
      if (hold)
        chk("hold_stable", int'({out_valid, out_data, out_ch, out_row, out_col, out_last}), held);
      hold = 1'b0;
      if (done) begin
        chk("done_after_last", cyc, last_hs_cyc + 1);
        chk("beat_count", idx, NB);
        chk("in_ready_at_done", int'(in_ready), 1);
        idx = 0;
        done_cyc = cyc;
        frames++;
      end
      if (out_valid) begin
        if (idx >= NB) begin
          chk("extra_beat", idx, NB - 1);
        end else begin
          if (idx == 0 && !was_hold) first_cyc = cyc;
          ech = idx / (PD * PD);
          er  = (idx / PD) % PD;
          ec  = idx % PD;
          chk("beat_data", int'(out_data), model_px(ech, er, ec));
          chk("beat_ch", int'(out_ch), ech);
          chk("beat_row", int'(out_row), er);
          chk("beat_col", int'(out_col), ec);
          chk("beat_last", int'(out_last), (idx == NB - 1) ? 1 : 0);
          cap[idx] = int'(out_data);
          if (out_ready) begin
            last_hs_cyc = cyc;
            idx++;
          end else begin
            hold = 1'b1;
            held = int'({1'b1, out_data, out_ch, out_row, out_col, out_last});
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic fill(input int v);
    for (int k = 0; k < CH; k++)
      for (int y = 0; y < FD; y++)
        for (int x = 0; x < FD; x++)
          fm[k][y][x] = BW'(v);
  endtask

  task automatic set_ramp();
    for (int k = 0; k < CH; k++)
      for (int y = 0; y < FD; y++)
        for (int x = 0; x < FD; x++)
          fm[k][y][x] = BW'(k * 1000 + y * 28 + x);
  endtask

  task automatic start_frame(output int t);
    @(posedge clk);
    #1;
    chk("in_ready_idle", int'(in_ready), 1);
    in_valid = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_frame(input string nm);
    int f0, n;
    f0 = frames;
    n = 0;
    while (frames == f0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (frames == f0) chk({nm, "_timeout"}, frames - f0, 1);
  endtask

  initial begin
    int t, n, d1;
    fm = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_row", int'(out_row), 0);
    chk("rst_out_col", int'(out_col), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // ramp map, free-flowing consumer
    set_ramp();
    start_frame(t);
    wait_frame("ramp");
    chk("ramp_first_cycle", first_cyc, t + 2);
    chk("ramp_last_cycle", last_hs_cyc, t + 393);
    chk("ramp_done_cycle", done_cyc, t + 394);
    chk("ramp_px_000", cap[0], 29);
    chk("ramp_px_001", cap[1], 31);
    chk("ramp_px_last", cap[NB-1], 1783);

    // all negative plus one mixed window at (0,5,6)
    fill(-5);
    fm[0][10][12] = BW'(-3);
    fm[0][10][13] = BW'(7);
    fm[0][11][12] = BW'(-1);
    fm[0][11][13] = BW'(2);
    start_frame(t);
    wait_frame("neg");
    chk("neg_px_first", cap[0], 0);
    chk("neg_px_window", cap[76], 7);
    chk("neg_px_last", cap[NB-1], 0);

    // signed extremes at (1,2,3) and (1,4,4)
    fill(-5);
    fm[1][4][6] = BW'(-32768);
    fm[1][4][7] = BW'(32767);
    fm[1][5][6] = BW'(0);
    fm[1][5][7] = BW'(0);
    fm[1][8][8] = BW'(-32768);
    fm[1][8][9] = BW'(-32768);
    fm[1][9][8] = BW'(-32768);
    fm[1][9][9] = BW'(-1);
    start_frame(t);
    wait_frame("ext");
    chk("ext_px_max", cap[227], 32767);
    chk("ext_px_neg", cap[256], 0);

    // random backpressure
    set_ramp();
    bp_mode = 1'b1;
    start_frame(t);
    wait_frame("bp");
    bp_mode = 1'b0;
    chk("bp_px_000", cap[0], 29);
    chk("bp_px_last", cap[NB-1], 1783);

    // reset in the middle of a frame
    start_frame(t);
    n = 0;
    while (idx < 100 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("midrst_reached_100", (idx >= 100) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_done", int'(done), 0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_done", int'(done), 0);
    end
    start_frame(t);
    wait_frame("after_rst");
    chk("after_rst_first_cycle", first_cyc, t + 2);
    chk("after_rst_px_000", cap[0], 29);

    // back-to-back frames with in_valid held
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    wait_frame("b2b1");
    d1 = done_cyc;
    n = 0;
    while (first_cyc <= d1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("b2b_second_first_beat", first_cyc, d1 + 2);
    in_valid = 1'b0;
    wait_frame("b2b2");
    chk("b2b_px_last", cap[NB-1], 1783);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmap_pool_streamer.md
# fmap_pool_streamer

- Consumer end of the first conv layer's parallel feature-map interface.
- Accepts a complete `CHANNELS x FMAP_DIM x FMAP_DIM` signed feature map with a valid/ready start handshake, then walks it sequentially.
- Applies 2x2 max-pooling followed by ReLU and streams the pooled pixels out one per beat on a valid/ready stream.
- Feeds the serial second stage of the LeNet pipeline.

## Interface
Parameters:
- `BITWIDTH`, 16, signed pixel width, same as the conv layer.
- `CHANNELS`, 2, number of feature maps.
- `FMAP_DIM`, 28, input map side; must be even. Pooled side `PDIM = FMAP_DIM/2`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `featuremap` input `[CHANNELS-1:0][FMAP_DIM-1:0][FMAP_DIM-1:0]` x `BITWIDTH` signed: feature map; upstream holds it stable from accept until `done`.
- `in_valid` input 1: feature map ready for consumption.
- `in_ready` output 1: high only in IDLE.
- `out_data` output `BITWIDTH` signed: pooled, ReLU'd pixel.
- `out_ch` output `$clog2(CHANNELS)`: channel of `out_data`.
- `out_row`, `out_col` output `$clog2(PDIM)` each: pooled coordinates.
- `out_last` output 1: high on the final beat of the frame.
- `out_valid` output 1: output beat valid.
- `out_ready` input 1: downstream accepts.
- `done` output 1: one-cycle pulse after the last beat is accepted.

## Operation
- FSM states: IDLE, STREAM, DRAIN.
- IDLE:
  - `in_ready=1`.
  - On `in_valid && in_ready`, clear counters `{ch,r,c}` and go to STREAM.
- STREAM:
  - On each load slot (`!out_valid || out_ready`), register the beat for the current `{ch,r,c}` and advance the counters.
  - Counter order: `c` fastest, then `r`, then `ch`.
  - The load that registers `{CHANNELS-1,PDIM-1,PDIM-1}` sets `out_last` and moves to DRAIN.
- DRAIN: hold until `out_valid && out_ready`, then clear `out_valid`, go to IDLE, and pulse `done`.
- Beat value:
  - `m = max` of `featuremap[ch][2r][2c]`, `[2r][2c+1]`, `[2r+1][2c]`, `[2r+1][2c+1]`, all signed compares.
  - `out_data = (m < 0) ? 0 : m`.
  - No widening and no saturation; the result is always exactly representable.
- Output register holds all fields stable while `out_valid && !out_ready`.
- `in_valid` outside IDLE is ignored. The feature map is not captured internally.
- `rst_n=0` at any cycle, including mid-frame: next edge goes to IDLE; the frame is abandoned with no `done`.
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_ch=0`, `out_row=0`, `out_col=0`, `out_last=0`, `done=0`.
  - `in_ready=1` in the first cycle after reset.

## Timing
- Frame accepted at cycle T, `state=STREAM` at T+1.
- First beat `(0,0,0)` valid at T+2.
- With `out_ready` held high: one beat per cycle, `CHANNELS*PDIM*PDIM` beats (392 at defaults). Last beat is at T+393 with `out_last=1`.
- `done=1` and `in_ready=1` at T+394. A new frame may be accepted in that same cycle.
- Backpressure:
  - Each low cycle of `out_ready` while `out_valid=1` adds exactly one cycle.
  - No beat is lost or duplicated.
  - The combinational path from `out_ready` to state is allowed; there is no skid buffer.
- Pool and ReLU datapath: one 4:1 mux tree per window position plus three comparators, single cycle, between the counters and the output register.

## Structure
- Shared package `lenet_pkg` holds:
  - The pixel typedef `pixel_t` (`logic signed [BITWIDTH-1:0]`).
  - `FMAP_DIM` and `CHANNELS` defaults.
  - The FSM enum `pool_state_e`.
- One natural sub-module: `max4_relu`, combinational. It takes four signed pixels and returns the ReLU of their max, reusable by later pooling stages.
- Counters and FSM live in the top module.

## Test plan
- Ramp map: `featuremap[ch][y][x] = ch*1000 + y*28 + x`, `out_ready=1`.
  - Expect 392 beats from T+2 to T+393.
  - Beat `(0,0,0)` = 29; beat `(1,13,13)` = 1783 with `out_last=1`.
  - `done` at T+394.
- All-negative map (every pixel -5): every beat is 0. A single window with values {-3, 7, -1, 2} gives 7 at that position.
- Signed extremes: window {-32768, 32767, 0, 0} gives 32767; window {-32768, -32768, -32768, -1} gives 0.
- Backpressure: toggle `out_ready` 1-0-0-1 pseudorandomly.
  - Held beats stay stable; the 392 beats arrive in order with no gaps in the sequence.
  - `done` comes exactly one cycle after the `out_last` handshake.
- Reset mid-frame at beat 100:
  - Next cycle `out_valid=0`, `in_ready=1`, no `done`.
  - A fresh frame accepted afterwards starts at `(0,0,0)`.
- Back-to-back frames: `in_valid` held high. The second frame is accepted in the `done` cycle; its first beat appears 2 cycles later.
